alu1_serial_ctrl: RTL and testbench
===================================

# alu1_serial_ctrl

Bit-serial sequencer that runs a WIDTH-bit operation through a single `alu1` slice, one bit per clock, LSB first. It sits between a requester and the 1-bit ALU. It latches the operands and opcode on a valid/ready handshake, drives `alu1` select and carry-in each cycle, registers the carry/borrow between bit positions, and presents the assembled word plus final carry on a second valid/ready handshake. This lets one `alu1` instance serve a word-wide datapath at the cost of WIDTH cycles per operation.

## Interface
- `WIDTH`, default 4: operand/result width in bits; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_valid` in 1: request present.
- `start_ready` out 1: block can accept a request.
- `op` in 3: operation select, sampled on the start handshake.
- `a` in WIDTH: operand A, sampled on the start handshake.
- `b` in WIDTH: operand B, sampled on the start handshake.
- `result_valid` out 1: result word and carry are valid.
- `result_ready` in 1: consumer accepts the result.
- `result` out WIDTH: assembled result word.
- `carry` out 1: final carry (ADD) or borrow (SUB); 0 for all other ops.

## Operation
- Opcode encoding is the `alu1` select value: AND=7, NOT=6, OR=5, XOR=4, ADD=3, SUB=2, TRANSFER=1, TEST=0.
  - TRANSFER and TEST yield `result`=0 and `carry`=0.
  - All 8 codes are legal.
- The state machine has three states: IDLE, RUN, DONE.
  - **IDLE**: `start_ready`=1. On `start_valid && start_ready`:
    - latch `op`, `a`, `b` into shift registers;
    - clear the bit counter and the carry flop;
    - go to RUN.
  - **RUN**: each cycle, `alu1` sees `a_sr[0]`, `b_sr[0]`, the carry flop, and latched `op`. On the clock edge:
    - shift A and B right;
    - shift `alu1.out` into `result` from the MSB side;
    - load the carry flop with `alu1.carry_out`;
    - increment the counter.
  - **RUN → DONE**: after the edge that processes bit WIDTH-1.
  - **DONE**: `result_valid`=1. `result` and `carry` are held stable until `result_ready`. On the handshake, go to IDLE.
- Carry-in for bit 0 is 0 for every op; SUB therefore computes A−B with borrow-in 0.
- `carry` output equals the carry flop after the last bit. It is forced to 0 when the latched op is not ADD/SUB.
- `start_ready` is 0 in RUN and DONE. Requests are never accepted in the same cycle as a result handshake.
- Width rules:
  - ADD result is (A+B) mod 2^WIDTH, with `carry` = bit WIDTH.
  - SUB result is (A−B) mod 2^WIDTH, with `carry`=1 iff A<B (unsigned).

## Timing
- Reset values: state=IDLE, `result`=0, `carry`=0, `result_valid`=0, counter=0, carry flop=0.
- `start_ready`=0 while `rst` is high and 1 in the first cycle after reset deassertion.
- Latency: if the start handshake occurs at edge k, `result_valid` rises after edge k+WIDTH.
- Throughput: at best one operation per WIDTH+2 cycles.
- `result_ready` held low keeps DONE indefinitely; outputs must not change.
- `rst` asserted in RUN or DONE: return to IDLE at the next edge and discard the operation. No `result_valid` pulse is produced for it.
- Inputs `a`, `b`, `op` may change freely outside the start handshake cycle without effect.
- Counter width is $clog2(WIDTH). Terminal-count comparison is against WIDTH-1; no wrap-around is used.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants `OP_AND`..`OP_TEST` (3-bit values above);
  - state enum constants `S_IDLE`, `S_RUN`, `S_DONE`.
- One sub-module: an `alu1` instance.
  - `carry_in` is driven from the carry flop, which is 0 during bit 0.
  - `select` is driven from the latched op.
- All other logic (shift registers, counter, FSM) is local.

## Test plan
- **ADD, WIDTH=4**, a=4'b0111, b=4'b0011, `result_ready`=1 → `result_valid` 4 cycles after accept, `result`=4'b1010, `carry`=0.
- **ADD overflow**, a=4'b1111, b=4'b0001 → `result`=4'b0000, `carry`=1. Then SUB a=4'b0011, b=4'b0101 → `result`=4'b1110, `carry`=1.
- **Logic ops**, a=4'b1100, b=4'b1010:
  - AND → 4'b1000;
  - OR → 4'b1110;
  - XOR → 4'b0110;
  - NOT → 4'b0011;
  - TRANSFER → 4'b0000;
  - `carry`=0 in every case.
- **Backpressure**: hold `result_ready`=0 for 10 cycles in DONE → `result`/`carry` stable and `start_ready`=0 throughout. `start_valid` pulses during RUN/DONE are ignored.
- **Reset mid-RUN**: assert `rst` after bit 1 of an ADD → next cycle state IDLE, `result`=0, `result_valid`=0. A following ADD 4'b0001+4'b0001 → 4'b0010.
- **Back-to-back**: `start_valid` held high with a stream of 5 random ops → each result matches the reference model. There is exactly one accept per completed result handshake.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: opcode values,
// sequencer states and a small opcode classification helper.
package alu_pkg;

    // alu1 select encodings (also the sequencer opcode)
    localparam logic [2:0] OP_AND      = 3'd7;
    localparam logic [2:0] OP_NOT      = 3'd6;
    localparam logic [2:0] OP_OR       = 3'd5;
    localparam logic [2:0] OP_XOR      = 3'd4;
    localparam logic [2:0] OP_ADD      = 3'd3;
    localparam logic [2:0] OP_SUB      = 3'd2;
    localparam logic [2:0] OP_TRANSFER = 3'd1;
    localparam logic [2:0] OP_TEST     = 3'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Only ADD and SUB report a carry/borrow; every other op reports 0
    function automatic logic op_is_arith(input logic [2:0] op_v);
        return (op_v == OP_ADD) || (op_v == OP_SUB);
    endfunction

endpackage

// File: rtl/alu1.sv
// One-bit ALU slice. ADD/SUB chain a carry (borrow for SUB) through
// carry_in/carry_out; all other operations ignore carry_in and return
// carry_out = 0.
module alu1
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [2:0] select,
    output logic       out,
    output logic       carry_out
);

    // Bit-level function select
    always_comb begin
        out       = 1'b0;
        carry_out = 1'b0;
        case (select)
            OP_AND: begin
                out = a & b;
            end
            OP_NOT: begin
                out = ~a;
            end
            OP_OR: begin
                out = a | b;
            end
            OP_XOR: begin
                out = a ^ b;
            end
            OP_ADD: begin
                out       = a ^ b ^ carry_in;
                carry_out = (a & b) | (carry_in & (a ^ b));
            end
            OP_SUB: begin
                // a - b - borrow_in; carry_out is the borrow to the next bit
                out       = a ^ b ^ carry_in;
                carry_out = (~a & b) | (~(a ^ b) & carry_in);
            end
            OP_TRANSFER: begin
                out = 1'b0;
            end
            OP_TEST: begin
                out = 1'b0;
            end
            default: begin
                out       = 1'b0;
                carry_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu1_serial_ctrl.sv
// Bit-serial sequencer: runs a WIDTH-bit operation through one alu1 slice,
// LSB first, one bit per clock. Operands are captured on the start
// handshake, the word result and final carry are offered on the result
// handshake.
module alu1_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_s;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] result_r;
    logic [CW-1:0]    cnt_r;
    logic             cflag_r;
    logic             carry_r;
    logic             result_valid_r;

    logic             start_ready_s;
    logic             accept_s;
    logic             last_bit_s;
    logic             alu_out_s;
    logic             alu_cout_s;

    // Ready only in IDLE and never while reset is being applied
    assign start_ready_s = (state_r == S_IDLE) && !rst;
    assign accept_s      = start_valid && start_ready_s;
    assign last_bit_s    = (cnt_r == CNT_LAST);

    assign start_ready  = start_ready_s;
    assign result_valid = result_valid_r;
    assign result       = result_r;
    assign carry        = carry_r;

    alu1 u_alu1 (
        .a         (a_sr_r[0]),
        .b         (b_sr_r[0]),
        .carry_in  (cflag_r),
        .select    (op_r),
        .out       (alu_out_s),
        .carry_out (alu_cout_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_valid) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_bit_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Operand capture, bit shifting, carry chaining and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r           <= 3'd0;
            a_sr_r         <= '0;
            b_sr_r         <= '0;
            result_r       <= '0;
            cnt_r          <= '0;
            cflag_r        <= 1'b0;
            carry_r        <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            result_valid_r <= (state_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r    <= op;
                        a_sr_r  <= a;
                        b_sr_r  <= b;
                        cnt_r   <= '0;
                        cflag_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                    result_r <= {alu_out_s, result_r[WIDTH-1:1]};
                    cflag_r  <= alu_cout_s;
                    if (last_bit_s) begin
                        // Counter parks at the terminal value until the next accept
                        carry_r <= op_is_arith(op_r) ? alu_cout_s : 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_DONE: begin
                    // Result and carry held until the consumer takes them
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu1_serial_ctrl.sv
// Scoreboard bench for alu1_serial_ctrl (WIDTH=4): expectations are queued
// when a start handshake is seen and checked when the result handshake occurs.
module tb_alu1_serial_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] result;
    logic         carry;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int accepts = 0;
    int results = 0;
    int last_acc = -1;
    bit b2b_mode = 1'b0;
    bit prev_v   = 1'b0;

    logic [W-1:0] exp_res_n;
    logic         exp_c_n;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        int           cyc;
    } exp_t;
    exp_t q[$];

    alu1_serial_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .carry        (carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Word-level reference for the random stream
    function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x - y;
        case (o)
            3'd7: return {1'b0, x & y};
            3'd6: return {1'b0, ~x};
            3'd5: return {1'b0, x | y};
            3'd4: return {1'b0, x ^ y};
            3'd3: return {1'b0, x} + {1'b0, y};
            3'd2: return {(x < y), d};
            default: return '0;
        endcase
    endfunction

    // Accept side: push expectation when a start handshake is about to happen
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else if (start_valid && start_ready) begin
            q.push_back('{res: exp_res_n, c: exp_c_n, cyc: cyc + 1});
            if (b2b_mode && last_acc >= 0)
                chk("accept_spacing", (cyc + 1) - last_acc, W + 2);
            last_acc = cyc + 1;
            accepts++;
        end
    end

    // Result side: latency on rising valid, data on the result handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (result_valid && !prev_v) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none", result);
                end else begin
                    chk("latency", cyc - q[0].cyc, W);
                end
            end
            if (result_valid && result_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("result", result, e.res);
                chk("carry", carry, e.c);
                results++;
            end
            prev_v = result_valid;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic ec, input bit keep);
        bit ok;
        op = o; a = x; b = y;
        exp_res_n = er; exp_c_n = ec;
        start_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (start_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL start_timeout actual=no_ready required=ready");
        end
        @(posedge clk); #1;
        if (!keep) start_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 3'($urandom);
    endtask

    task automatic wait_results(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (results >= n) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL result_timeout actual=%0d required=%0d", results, n);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, res0, n;
        logic [2:0] ro;
        logic [W-1:0] ra, rb;
        logic [W:0] m;

        rst = 1'b1; start_valid = 1'b0; result_ready = 1'b1;
        op = 3'd0; a = '0; b = '0; exp_res_n = '0; exp_c_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_start_ready", start_ready, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_start_ready", start_ready, 1);
        @(posedge clk); #1;

        // Arithmetic
        issue(3'd3, 4'b0111, 4'b0011, 4'b1010, 1'b0, 1'b0); wait_results(1);
        issue(3'd3, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0); wait_results(2);
        issue(3'd2, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0); wait_results(3);
        issue(3'd2, 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0); wait_results(4);

        // Logic ops (carry always 0)
        issue(3'd7, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0); wait_results(5);
        issue(3'd5, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0); wait_results(6);
        issue(3'd4, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0); wait_results(7);
        issue(3'd6, 4'b1100, 4'b1010, 4'b0011, 1'b0, 1'b0); wait_results(8);
        issue(3'd1, 4'b1100, 4'b1010, 4'b0000, 1'b0, 1'b0); wait_results(9);
        issue(3'd0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0); wait_results(10);

        // Backpressure with ignored start pulses
        result_ready = 1'b0;
        issue(3'd3, 4'b0111, 4'b0011, 4'b1010, 1'b0, 1'b0);
        n = 0;
        while (!result_valid && n < 20) begin
            start_valid = ~start_valid;
            a = 4'b1111; b = 4'b1111;
            @(negedge clk);
            chk("run_start_ready", start_ready, 0);
            n++;
        end
        chk("bp_reached_done", result_valid, 1);
        for (int i = 0; i < 10; i++) begin
            start_valid = (i % 2) == 0;
            @(negedge clk);
            chk("bp_result", result, 4'b1010);
            chk("bp_carry", carry, 0);
            chk("bp_valid", result_valid, 1);
            chk("bp_start_ready", start_ready, 0);
            @(posedge clk); #1;
        end
        start_valid = 1'b0;
        result_ready = 1'b1;
        wait_results(11);
        chk("bp_accepts", accepts, 11);

        // Reset in the middle of RUN, after bit 1
        issue(3'd3, 4'b0111, 4'b0011, 4'b1010, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_result", result, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_start_ready", start_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle_ready", start_ready, 1);
        @(posedge clk); #1;
        issue(3'd3, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0); wait_results(12);

        // Back-to-back stream with start_valid held high
        acc0 = accepts; res0 = results;
        b2b_mode = 1'b1; last_acc = -1;
        for (int i = 0; i < 5; i++) begin
            ro = 3'($urandom); ra = W'($urandom); rb = W'($urandom);
            m = model(ro, ra, rb);
            issue(ro, ra, rb, m[W-1:0], m[W], (i < 4));
        end
        wait_results(res0 + 5);
        b2b_mode = 1'b0;
        chk("b2b_accepts", accepts - acc0, 5);
        chk("b2b_results", results - res0, 5);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
